// File: rtl/nfc_stim_pkg.sv
// Shared types for the NFC ASK stimulus generator: FSM state encoding and the
// {last,data} entry carried through the bit FIFO.
package nfc_stim_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SOF,
        DATA,
        EOF
    } state_t;

    typedef struct packed {
        logic last;
        logic data;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/nfc_ask_stim_gen_if.sv
// Valid/ready bit-stream channel feeding the stimulus generator's bit FIFO.
interface nfc_ask_stim_gen_if;

    logic s_valid;
    logic s_ready;
    logic s_data;
    logic s_last;

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        output s_ready
    );

endinterface

// File: rtl/nfc_stim_fifo.sv
// Synchronous FIFO with wrap-bit pointers; pushes into a full FIFO and pops
// from an empty one are ignored.
module nfc_stim_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign count_o   = wr_ptr_q - rd_ptr_q;
    assign full_o    = (count_o == CNT_W'(DEPTH));
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + CNT_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries no reset: occupancy is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/nfc_ask_stim_gen.sv
// NFC ASK stimulus source: NCO square carrier whose slewed envelope is keyed by
// SOF / FIFO data bits / EOF frames. v_out is a registered signed sample.
module nfc_ask_stim_gen
    import nfc_stim_pkg::*;
#(
    parameter int PHASE_W    = 32,
    parameter int AMP_W      = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int BITCNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PHASE_W-1:0]      cfg_phase_inc,
    input  logic [AMP_W-1:0]        cfg_amp_hi,
    input  logic [AMP_W-1:0]        cfg_amp_lo,
    input  logic [BITCNT_W-1:0]     cfg_bit_period,
    input  logic [AMP_W-1:0]        cfg_ramp_step,
    input  logic                    enable,
    nfc_ask_stim_gen_if.slave       s_if,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    underrun,
    output logic signed [AMP_W:0]   v_out
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    function automatic logic [AMP_W-1:0] slew_env(input logic [AMP_W-1:0] cur,
                                                  input logic [AMP_W-1:0] tgt,
                                                  input logic [AMP_W-1:0] step);
        logic [AMP_W-1:0] diff;
        if (step == '0) return tgt;
        if (tgt > cur) begin
            diff = tgt - cur;
            return (diff <= step) ? tgt : cur + step;
        end
        diff = cur - tgt;
        return (diff <= step) ? tgt : cur - step;
    endfunction

    // Magnitude is zero-extended first so negating 2^AMP_W-1 cannot overflow.
    function automatic logic signed [AMP_W:0] carrier_mod(input logic             hi,
                                                          input logic [AMP_W-1:0] env);
        logic signed [AMP_W:0] mag;
        mag = $signed({1'b0, env});
        return hi ? mag : -mag;
    endfunction

    state_t                 state_q;
    logic [BITCNT_W-1:0]    cnt_q;
    logic [BITCNT_W-1:0]    per_q;
    fifo_entry_t            cur_q;
    logic                   starve_q;
    logic                   underrun_q;
    logic                   frame_done_q;
    logic [PHASE_W-1:0]     phase_q;
    logic [AMP_W-1:0]       env_tgt_q, env_tgt_d;
    logic [AMP_W-1:0]       env_q, env_d;
    logic signed [AMP_W:0]  v_out_q, v_out_d;

    fifo_entry_t            wr_entry;
    fifo_entry_t            rd_entry;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_cnt;
    logic                   fifo_avail;
    logic                   pop_req;
    logic                   fifo_pop;
    logic [BITCNT_W-1:0]    eff_per;
    logic                   bit_end;

    assign wr_entry    = '{last: s_if.s_last, data: s_if.s_data};
    assign s_if.s_ready = !fifo_full;
    assign fifo_avail  = (fifo_cnt != '0);
    assign fifo_pop    = pop_req && fifo_avail && !fifo_empty;

    nfc_stim_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push_i    (s_if.s_valid),
        .pop_i     (fifo_pop),
        .wr_data_i (wr_entry),
        .rd_data_o (rd_entry),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_cnt)
    );

    assign eff_per = (cfg_bit_period == '0) ? BITCNT_W'(1) : cfg_bit_period;
    assign bit_end = (cnt_q == per_q - BITCNT_W'(1));

    always_comb begin
        pop_req   = 1'b0;
        env_tgt_d = cfg_amp_hi;
        case (state_q)
            SOF: begin
                env_tgt_d = cfg_amp_lo;
                pop_req   = bit_end;
            end
            DATA: begin
                if (starve_q) begin
                    env_tgt_d = cfg_amp_hi;
                    pop_req   = 1'b1;
                end else begin
                    env_tgt_d = cur_q.data ? cfg_amp_hi : cfg_amp_lo;
                    pop_req   = bit_end && !cur_q.last;
                end
            end
            default: env_tgt_d = cfg_amp_hi;
        endcase
    end

    // Frame sequencer; the bit period is latched on every bit start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            per_q        <= BITCNT_W'(1);
            cur_q        <= '0;
            starve_q     <= 1'b0;
            underrun_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            cnt_q        <= cnt_q + BITCNT_W'(1);
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (enable && fifo_avail) begin
                        state_q    <= SOF;
                        per_q      <= eff_per;
                        starve_q   <= 1'b0;
                        underrun_q <= 1'b0;
                    end
                end
                SOF: begin
                    if (bit_end) begin
                        state_q <= DATA;
                        cnt_q   <= '0;
                        per_q   <= eff_per;
                        if (fifo_pop) begin
                            cur_q <= rd_entry;
                        end else begin
                            starve_q   <= 1'b1;
                            underrun_q <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (starve_q) begin
                        cnt_q <= '0;
                        if (fifo_pop) begin
                            cur_q    <= rd_entry;
                            per_q    <= eff_per;
                            starve_q <= 1'b0;
                        end
                    end else if (bit_end) begin
                        cnt_q <= '0;
                        per_q <= eff_per;
                        if (cur_q.last) begin
                            state_q <= EOF;
                        end else if (fifo_pop) begin
                            cur_q <= rd_entry;
                        end else begin
                            starve_q   <= 1'b1;
                            underrun_q <= 1'b1;
                        end
                    end
                end
                EOF: begin
                    if (bit_end) begin
                        state_q      <= IDLE;
                        cnt_q        <= '0;
                        frame_done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign env_d   = slew_env(env_q, env_tgt_q, cfg_ramp_step);
    assign v_out_d = carrier_mod(~phase_q[PHASE_W-1], env_q);

    // Target -> envelope -> output, one register each.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q   <= '0;
            env_tgt_q <= '0;
            env_q     <= '0;
            v_out_q   <= '0;
        end else begin
            phase_q   <= phase_q + cfg_phase_inc;
            env_tgt_q <= env_tgt_d;
            env_q     <= env_d;
            v_out_q   <= v_out_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;
    assign v_out      = v_out_q;

endmodule

// File: tb/tb_nfc_ask_stim_gen.sv
// Directed and randomised checks of nfc_ask_stim_gen against a queue-based
// frame/envelope timeline model.
module tb_nfc_ask_stim_gen;

    logic               clk;
    logic               rst;
    logic [7:0]         cfg_phase_inc;
    logic [15:0]        cfg_amp_hi;
    logic [15:0]        cfg_amp_lo;
    logic [15:0]        cfg_bit_period;
    logic [15:0]        cfg_ramp_step;
    logic               enable;
    logic               busy;
    logic               frame_done;
    logic               underrun;
    logic signed [16:0] v_out;

    int checks = 0;
    int errors = 0;
    bit [1:0] q[$];

    nfc_ask_stim_gen_if sif ();

    nfc_ask_stim_gen #(
        .PHASE_W    (8),
        .AMP_W      (16),
        .FIFO_DEPTH (8),
        .BITCNT_W   (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_phase_inc  (cfg_phase_inc),
        .cfg_amp_hi     (cfg_amp_hi),
        .cfg_amp_lo     (cfg_amp_lo),
        .cfg_bit_period (cfg_bit_period),
        .cfg_ramp_step  (cfg_ramp_step),
        .enable         (enable),
        .s_if           (sif),
        .busy           (busy),
        .frame_done     (frame_done),
        .underrun       (underrun),
        .v_out          (v_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Envelope moves toward the target by at most step per cycle.
    function automatic int slew(input int e, input int t, input int s);
        if (s == 0) return t;
        if (t > e) return (t - e <= s) ? t : e + s;
        return (e - t <= s) ? t : e - s;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        q.delete();
        repeat (3) step();
        rst = 1'b1;
    endtask

    task automatic settle();
        repeat (70) step();
    endtask

    task automatic push_bit(input bit last, input bit data);
        sif.s_valid = 1'b1;
        sif.s_last  = last;
        sif.s_data  = data;
        chk("push_ready", sif.s_ready, 1);
        step();
        sif.s_valid = 1'b0;
        q.push_back({last, data});
    endtask

    // Builds the target-level timeline of the next queued frame, starts it and
    // compares v_out, frame_done and busy on every cycle through to idle.
    task automatic run_frame();
        int p, L, menv, mtgt, vexp, hi, lo;
        int tl[$];
        bit [1:0] e;
        hi = int'(cfg_amp_hi);
        lo = int'(cfg_amp_lo);
        p  = (cfg_bit_period == 16'd0) ? 1 : int'(cfg_bit_period);
        repeat (p) tl.push_back(lo);
        do begin
            e = q.pop_front();
            repeat (p) tl.push_back(e[0] ? hi : lo);
        end while (!e[1] && q.size() > 0);
        repeat (p) tl.push_back(hi);
        L    = tl.size();
        menv = hi;
        mtgt = hi;
        enable = 1'b1;
        step();
        enable = 1'b0;
        chk("sof_busy", busy, 1);
        chk("sof_underrun_clear", underrun, 0);
        for (int m = 1; m <= L + 4; m++) begin
            vexp = menv;
            menv = slew(menv, mtgt, int'(cfg_ramp_step));
            mtgt = (m - 1 < L) ? tl[m-1] : hi;
            step();
            chk("frame_vout", int'(v_out), vexp);
            chk("frame_done", frame_done, (m == L));
            chk("frame_busy", busy, (m < L));
        end
    endtask

    initial begin
        int  exp_v;
        int  na, nb;
        bit  d, exp_rdy, seen;
        int  ramp_exp[7];

        rst            = 1'b1;
        cfg_phase_inc  = 8'd0;
        cfg_amp_hi     = 16'd1000;
        cfg_amp_lo     = 16'd500;
        cfg_bit_period = 16'd4;
        cfg_ramp_step  = 16'd250;
        enable         = 1'b0;
        sif.s_valid    = 1'b0;
        sif.s_data     = 1'b0;
        sif.s_last     = 1'b0;
        #2;

        // Reset state, then ramp to amp_hi after release.
        rst = 1'b0;
        repeat (5) step();
        chk("rst_vout", int'(v_out), 0);
        chk("rst_ready", sif.s_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_underrun", underrun, 0);
        rst = 1'b1;
        ramp_exp = '{0, 0, 250, 500, 750, 1000, 1000};
        for (int i = 0; i < 7; i++) begin
            step();
            chk("rst_ramp_vout", int'(v_out), ramp_exp[i]);
        end

        // Carrier: 32/256 per cycle gives 4 cycles high, 4 low.
        cfg_ramp_step = 16'd0;
        cfg_phase_inc = 8'd32;
        for (int m = 1; m <= 16; m++) begin
            step();
            exp_v = ((((m - 1) * 32) % 256) < 128) ? 1000 : -1000;
            chk("carrier_vout", int'(v_out), exp_v);
        end
        cfg_phase_inc = 8'd0;
        do_reset();
        settle();

        // Directed frame 1,0,1(last) at period 4.
        push_bit(1'b0, 1'b1);
        push_bit(1'b0, 1'b0);
        push_bit(1'b1, 1'b1);
        run_frame();

        // Backpressure: ten offers, eight fit.
        for (int i = 0; i < 10; i++) begin
            d = 1'($urandom_range(1));
            sif.s_valid = 1'b1;
            sif.s_data  = d;
            sif.s_last  = (i == 7);
            exp_rdy = (q.size() < 8);
            chk("bp_ready", sif.s_ready, exp_rdy);
            if (exp_rdy) q.push_back({(i == 7), d});
            step();
        end
        sif.s_valid = 1'b0;
        chk("bp_full_ready", sif.s_ready, 0);
        chk("bp_no_start", busy, 0);
        cfg_bit_period = 16'd2;
        run_frame();

        // Underrun: one data bit, then starve.
        cfg_bit_period = 16'd4;
        push_bit(1'b0, 1'b0);
        q.delete();
        enable = 1'b1;
        step();
        enable = 1'b0;
        repeat (7) step();
        chk("underrun_before", underrun, 0);
        step();
        chk("underrun_set", underrun, 1);
        repeat (10) step();
        chk("underrun_vout_hi", int'(v_out), 1000);
        chk("underrun_busy", busy, 1);
        push_bit(1'b1, 1'b1);
        q.delete();
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (frame_done) seen = 1'b1;
        end
        chk("underrun_frame_done_seen", seen, 1);
        chk("underrun_sticky", underrun, 1);
        chk("underrun_idle", busy, 0);
        step();
        chk("underrun_sticky_idle", underrun, 1);
        push_bit(1'b1, 1'b0);
        run_frame();

        // Slewed envelope: 1000 -> 500 in steps of 100.
        cfg_ramp_step  = 16'd100;
        cfg_bit_period = 16'd8;
        push_bit(1'b0, 1'b1);
        push_bit(1'b1, 1'b0);
        run_frame();

        // Asynchronous reset mid-DATA discards the frame and the FIFO.
        cfg_ramp_step  = 16'd0;
        cfg_bit_period = 16'd4;
        push_bit(1'b0, 1'b1);
        push_bit(1'b0, 1'b0);
        push_bit(1'b1, 1'b1);
        enable = 1'b1;
        step();
        enable = 1'b0;
        repeat (6) step();
        chk("mid_busy_before", busy, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_vout", int'(v_out), 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", sif.s_ready, 1);
        step();
        step();
        rst = 1'b1;
        q.delete();
        enable = 1'b1;
        repeat (6) step();
        chk("mid_rst_fifo_empty", busy, 0);
        enable = 1'b0;

        // Random back-to-back frames; the second must wait for enable.
        for (int it = 0; it < 6; it++) begin
            cfg_amp_hi     = 16'($urandom_range(65535));
            cfg_amp_lo     = 16'($urandom_range(65535));
            cfg_bit_period = 16'($urandom_range(5, 0));
            cfg_ramp_step  = ($urandom_range(1) == 0) ? 16'd0 : 16'(1024 + $urandom_range(3000));
            settle();
            na = $urandom_range(4, 1);
            nb = $urandom_range(4, 1);
            for (int i = 0; i < na; i++) push_bit((i == na - 1), 1'($urandom_range(1)));
            for (int i = 0; i < nb; i++) push_bit((i == nb - 1), 1'($urandom_range(1)));
            run_frame();
            chk("rand_no_restart", busy, 0);
            run_frame();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
